mem_port_arbiter: RTL and testbench

//  Shares the CPU's single-port memory between instruction fetch (IF state) and data

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_arb_watchdog.sv | 35 +++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default widths for the CPU memory-port arbiter.
package cpu_mem_defs;

  localparam int DEF_ADDR_W  = 64;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Access watchdog: counts ACCESS cycles without mem_ready; expired flags the abort cycle.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, strict alternation.
// Optional access watchdog enabled by defining MEM_ARB_WATCHDOG_EN.
//   state  | meaning
//   IDLE   | port free, arbitrate pending requests
//   ACCESS | mem_en held, waiting for mem_ready (or watchdog abort)
//   DONE   | owner's done pulse, requests ignored
module mem_port_arbiter
  import cpu_mem_defs::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              err
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              err_q, err_d;
  logic              grant;
  logic [DATA_W-1:0] cap_data;
  logic              wd_expired;

`ifdef MEM_ARB_WATCHDOG_EN
  logic wd_clear, wd_count_en;

  assign wd_clear    = (state_q != ST_ACCESS);
  assign wd_count_en = (state_q == ST_ACCESS) && !mem_ready;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .clear    (wd_clear),
    .count_en (wd_count_en),
    .expired  (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    grant       = owner_q;
    cap_data    = '0;

    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          grant = (if_req && d_req) ? ~owner_q : d_req;
          owner_d  = grant;
          mem_en_d = 1'b1;
          state_d  = ST_ACCESS;
          if (grant == OWN_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ready || wd_expired) begin
          // ready on the abort cycle completes normally
          cap_data = (mem_ready && !mem_we_q) ? mem_rdata : '0;
          err_d    = !mem_ready;
          mem_en_d = 1'b0;
          state_d  = ST_DONE;
          if (owner_q == OWN_D) begin
            d_rdata_d = cap_data;
            d_done_d  = 1'b1;
          end else begin
            if_rdata_d = cap_data;
            if_done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        mem_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_D;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed sequences, a cycle table and
// randomized traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req, d_req, d_we, mem_ready;
  logic [63:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [63:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_done, d_done, mem_en, mem_we, busy, err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .ADDR_W  (64),
    .DATA_W  (64),
    .TIMEOUT (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .err       (err)
  );

  typedef struct {
    logic        if_req;
    logic        d_req;
    logic        ready;
    logic [63:0] rdata_in;
    logic        en;
    logic        bsy;
    logic        ifd;
    logic        dd;
    logic [63:0] addr;
    logic [63:0] rd;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_inputs();
    if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clr_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // reference-model state for the random phase
  logic        last_own, exp_own;
  logic        p_busy, p_en, p_ready, p_if_req, p_d_req, p_d_we;
  logic [63:0] p_rdata, p_if_addr, p_d_addr, p_d_wdata;
  logic        acc_own, acc_we;
  logic [63:0] acc_addr, acc_wdata, e_if_rd, e_d_rd;
  int          wait_cnt;

  initial begin
    clr_inputs();

    // reset held with both requests pending
    reset = 1'b0;
    if_req = 1; d_req = 1; if_addr = 64'h100; d_addr = 64'h200; d_wdata = 64'h77;
    repeat (3) step();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("rst_rel_en", mem_en, 1);
    chk("rst_rel_fetch_first", mem_addr, 64'h100);
    chk("rst_rel_we", mem_we, 0);
    chk("rst_rel_wdata", mem_wdata, 0);
    mem_ready = 1; mem_rdata = 64'hABCD;
    step();
    chk("rst_rel_if_done", if_done, 1);
    chk("rst_rel_if_rdata", if_rdata, 64'hABCD);
    clr_inputs();
    step();

    // single load with ready on the second ACCESS cycle
    d_req = 1; d_we = 0; d_addr = 64'h40;
    step();
    chk("load_en", mem_en, 1);
    chk("load_addr", mem_addr, 64'h40);
    step();
    chk("load_wait_done", d_done, 0);
    mem_ready = 1; mem_rdata = 64'hDEAD;
    step();
    chk("load_d_done", d_done, 1);
    chk("load_d_rdata", d_rdata, 64'hDEAD);
    chk("load_if_done", if_done, 0);
    chk("load_en_off", mem_en, 0);
    clr_inputs();
    step();

    // contention with immediate ready: IF, D, IF, D
    do_reset();
    if_addr = 64'h100; d_addr = 64'h200;
    tbl[0]  = '{1, 1, 1, 64'hA0, 1, 1, 0, 0, 64'h100, 64'h0};
    tbl[1]  = '{1, 1, 1, 64'hA1, 0, 1, 1, 0, 64'h0,   64'hA1};
    tbl[2]  = '{1, 1, 1, 64'hA2, 0, 0, 0, 0, 64'h0,   64'h0};
    tbl[3]  = '{1, 1, 1, 64'hA3, 1, 1, 0, 0, 64'h200, 64'h0};
    tbl[4]  = '{1, 1, 1, 64'hA4, 0, 1, 0, 1, 64'h0,   64'hA4};
    tbl[5]  = '{1, 1, 1, 64'hA5, 0, 0, 0, 0, 64'h0,   64'h0};
    tbl[6]  = '{1, 1, 1, 64'hA6, 1, 1, 0, 0, 64'h100, 64'h0};
    tbl[7]  = '{1, 1, 1, 64'hA7, 0, 1, 1, 0, 64'h0,   64'hA7};
    tbl[8]  = '{1, 1, 1, 64'hA8, 0, 0, 0, 0, 64'h0,   64'h0};
    tbl[9]  = '{1, 1, 1, 64'hA9, 1, 1, 0, 0, 64'h200, 64'h0};
    tbl[10] = '{1, 1, 1, 64'hAA, 0, 1, 0, 1, 64'h0,   64'hAA};
    for (int i = 0; i < 11; i++) begin
      if_req = tbl[i].if_req; d_req = tbl[i].d_req;
      mem_ready = tbl[i].ready; mem_rdata = tbl[i].rdata_in;
      step();
      chk($sformatf("tbl%0d_en", i), mem_en, tbl[i].en);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_if_done", i), if_done, tbl[i].ifd);
      chk($sformatf("tbl%0d_d_done", i), d_done, tbl[i].dd);
      if (tbl[i].en) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].addr);
      if (tbl[i].ifd) chk($sformatf("tbl%0d_if_rdata", i), if_rdata, tbl[i].rd);
      if (tbl[i].dd) chk($sformatf("tbl%0d_d_rdata", i), d_rdata, tbl[i].rd);
    end
    clr_inputs();
    step();

    // store: port values stable until ready, store returns zero data
    d_req = 1; d_we = 1; d_wdata = 64'h1234; d_addr = 64'h80;
    step();
    chk("st_we", mem_we, 1);
    chk("st_wdata", mem_wdata, 64'h1234);
    chk("st_addr", mem_addr, 64'h80);
    step();
    chk("st_we_hold", mem_we, 1);
    chk("st_wdata_hold", mem_wdata, 64'h1234);
    chk("st_addr_hold", mem_addr, 64'h80);
    chk("st_en_hold", mem_en, 1);
    mem_ready = 1; mem_rdata = 64'hFFFF;
    step();
    chk("st_d_done", d_done, 1);
    chk("st_d_rdata", d_rdata, 0);
    clr_inputs();
    step();

    // reset mid-ACCESS, then the held request is granted again
    d_req = 1; d_we = 0; d_addr = 64'h500;
    step();
    chk("rma_en", mem_en, 1);
    step();
    #1 reset = 1'b0;
    #1;
    chk("rma_en_async", mem_en, 0);
    chk("rma_busy", busy, 0);
    chk("rma_no_done", d_done, 0);
    step();
    chk("rma_no_done2", d_done, 0);
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("rma_regrant_en", mem_en, 1);
    chk("rma_regrant_addr", mem_addr, 64'h500);
    mem_ready = 1; mem_rdata = 64'h5555;
    step();
    chk("rma_d_done", d_done, 1);
    chk("rma_d_rdata", d_rdata, 64'h5555);
    clr_inputs();
    step();

    // ready never arrives
    d_req = 1; d_we = 0; d_addr = 64'h300;
    step();
    chk("wd_en", mem_en, 1);
`ifdef MEM_ARB_WATCHDOG_EN
    for (int k = 2; k <= 16; k++) begin
      step();
      chk($sformatf("wd_wait%0d_done", k), d_done, 0);
      chk($sformatf("wd_wait%0d_en", k), mem_en, 1);
    end
    step();
    chk("wd_abort_done", d_done, 1);
    chk("wd_abort_err", err, 1);
    chk("wd_abort_rdata", d_rdata, 0);
    chk("wd_abort_en", mem_en, 0);
    d_req = 0;
    step();
    chk("wd_err_pulse", err, 0);
`else
    repeat (40) step();
    chk("nowd_busy", busy, 1);
    chk("nowd_en", mem_en, 1);
    chk("nowd_err", err, 0);
    chk("nowd_done", d_done, 0);
`endif

    // randomized traffic against the reference model
    do_reset();
    last_own = 1'b1;
    e_if_rd = 0; e_d_rd = 0;
    p_busy = 0; p_en = 0; p_ready = 0; p_if_req = 0; p_d_req = 0; p_d_we = 0;
    p_rdata = 0; p_if_addr = 0; p_d_addr = 0; p_d_wdata = 0;
    acc_own = 0; acc_we = 0; acc_addr = 0; acc_wdata = 0; wait_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!p_busy) begin
        if (p_if_req || p_d_req) begin
          exp_own   = (p_if_req && p_d_req) ? ~last_own : p_d_req;
          acc_own   = exp_own;
          acc_we    = exp_own ? p_d_we : 1'b0;
          acc_addr  = exp_own ? p_d_addr : p_if_addr;
          acc_wdata = exp_own ? p_d_wdata : 64'h0;
          last_own  = exp_own;
          chk("rnd_grant_en", mem_en, 1);
          chk("rnd_grant_addr", mem_addr, acc_addr);
          chk("rnd_grant_we", mem_we, acc_we);
          chk("rnd_grant_wdata", mem_wdata, acc_wdata);
          chk("rnd_grant_busy", busy, 1);
        end else begin
          chk("rnd_idle_en", mem_en, 0);
          chk("rnd_idle_busy", busy, 0);
        end
        chk("rnd_idle_if_done", if_done, 0);
        chk("rnd_idle_d_done", d_done, 0);
      end else if (p_en) begin
        if (p_ready) begin
          if (acc_own) e_d_rd = acc_we ? 64'h0 : p_rdata;
          else         e_if_rd = acc_we ? 64'h0 : p_rdata;
          chk("rnd_done_en", mem_en, 0);
          chk("rnd_done_if", if_done, !acc_own);
          chk("rnd_done_d", d_done, acc_own);
          chk("rnd_done_err", err, 0);
          chk("rnd_done_busy", busy, 1);
        end else begin
          chk("rnd_acc_en", mem_en, 1);
          chk("rnd_acc_addr", mem_addr, acc_addr);
          chk("rnd_acc_we", mem_we, acc_we);
          chk("rnd_acc_wdata", mem_wdata, acc_wdata);
          chk("rnd_acc_if_done", if_done, 0);
          chk("rnd_acc_d_done", d_done, 0);
        end
      end else begin
        chk("rnd_post_busy", busy, 0);
        chk("rnd_post_en", mem_en, 0);
        chk("rnd_post_if_done", if_done, 0);
        chk("rnd_post_d_done", d_done, 0);
      end
      chk("rnd_if_rdata", if_rdata, e_if_rd);
      chk("rnd_d_rdata", d_rdata, e_d_rd);

      if (if_done) if_req = 0;
      if (d_done)  d_req = 0;
      if (mem_en && $urandom_range(15) == 0) begin
        if (acc_own) d_req = 0;
        else         if_req = 0;
      end
      if (!if_req && !if_done && !(busy && acc_own == 1'b0) && $urandom_range(2) == 0) begin
        if_req  = 1;
        if_addr = {32'h0, $urandom};
      end
      if (!d_req && !d_done && !(busy && acc_own == 1'b1) && $urandom_range(2) == 0) begin
        d_req   = 1;
        d_we    = 1'($urandom_range(1));
        d_addr  = {32'h8000_0000, $urandom};
        d_wdata = {$urandom, $urandom};
      end
      if (mem_en) begin
        wait_cnt++;
        mem_ready = (wait_cnt >= 6) || ($urandom_range(2) == 0);
      end else begin
        wait_cnt  = 0;
        mem_ready = ($urandom_range(3) == 0);
      end
      mem_rdata = {$urandom, $urandom};

      p_busy = busy; p_en = mem_en; p_ready = mem_ready; p_rdata = mem_rdata;
      p_if_req = if_req; p_d_req = d_req; p_if_addr = if_addr;
      p_d_addr = d_addr; p_d_we = d_we; p_d_wdata = d_wdata;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
